// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared state encodings, constants and SPI mode helpers for spi_memory_gen.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        READ   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic RW_READ = 1'b1;

    // Sample on the rising sclk edge when CPOL == CPHA, otherwise on the falling edge.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return mode[1] ~^ mode[0];
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop pin synchroniser with a history flop producing rise/fall strobes.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= {STAGES{RST_VAL}};
            hist  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            hist  <= level;
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/spi_memory_gen.sv
// spi_memory_gen: parametrised SPI-slave memory with burst auto-increment, wrap and abort detection.
module spi_memory_gen
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic       busy,
    output logic       frame_err,
    output logic [1:0] dbg_state
);

    localparam logic CPOL        = (MODE & 2) != 0;
    localparam logic SAMPLE_RISE = sample_on_rise(2'(MODE));
    localparam int   BC_W        = $clog2((ADDR_W + 1 > DATA_W ? ADDR_W + 1 : DATA_W) + 1);
    localparam int   ST_W        = $clog2(SYNC_STAGES + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi, mosi_rise, mosi_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk (
        .clk(clk), .reset_n(reset_n), .pin(sclk_pin),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset_n(reset_n), .pin(cs_pin),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset_n(reset_n), .pin(mosi_pin),
        .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, sclk_level, mosi_rise, mosi_fall};

    state_t            state, state_n;
    logic [BC_W-1:0]   bitcnt;
    logic [ADDR_W-1:0] addr, hdr, rd_addr;
    logic [DATA_W-1:0] tx_reg, rx_reg, ram_q;
    logic              rd_pend, wr_pend, armed;
    logic [ST_W-1:0]   settle;
    logic              sample_stb, shift_stb, cs_start;
    logic              hdr_done, word_rd, word_wr, mem_re;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign sample_stb = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_stb  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    // A fall only counts once cs has been seen high after reset, so a reset mid-frame needs a fresh frame.
    assign cs_start   = cs_fall & armed;
    assign hdr_done   = state == HEADER && sample_stb && !cs_rise && bitcnt == BC_W'(ADDR_W);
    assign word_rd    = state == READ && shift_stb && !cs_rise && bitcnt == BC_W'(DATA_W - 1);
    assign word_wr    = state == WRITE && sample_stb && !cs_rise && bitcnt == BC_W'(DATA_W - 1);
    assign mem_re     = (hdr_done && mosi == RW_READ) || word_rd;
    assign rd_addr    = hdr_done ? hdr : addr + 1'b1;
    assign busy       = state != IDLE;
    assign dbg_state  = state;

    always_comb begin
        state_n = state;
        if (cs_rise)
            state_n = IDLE;
        else if (state == IDLE && cs_start)
            state_n = HEADER;
        else if (hdr_done)
            state_n = (mosi == RW_READ) ? READ : WRITE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bitcnt    <= '0;
            addr      <= '0;
            hdr       <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            rd_pend   <= 1'b0;
            wr_pend   <= 1'b0;
            miso_pin  <= 1'b0;
            miso_oe   <= 1'b0;
            frame_err <= 1'b0;
            armed     <= 1'b0;
            settle    <= '0;
        end else begin
            frame_err <= cs_rise && state != IDLE && bitcnt != '0;
            miso_oe   <= state_n == READ;
            rd_pend   <= mem_re;
            wr_pend   <= word_wr;
            settle    <= (settle == ST_W'(SYNC_STAGES)) ? settle : settle + 1'b1;
            armed     <= armed | ((settle == ST_W'(SYNC_STAGES)) & cs_level);
            if (rd_pend)
                tx_reg <= ram_q;
            if (wr_pend)
                addr <= addr + 1'b1;
            if (cs_rise || (state == IDLE && cs_start)) begin
                bitcnt <= '0;
            end else if (state == HEADER && sample_stb) begin
                hdr    <= {hdr[ADDR_W-2:0], mosi};
                bitcnt <= hdr_done ? '0 : bitcnt + 1'b1;
                if (hdr_done)
                    addr <= hdr;
            end else if (state == READ && shift_stb) begin
                miso_pin <= tx_reg[DATA_W-1];
                tx_reg   <= tx_reg << 1;
                bitcnt   <= word_rd ? '0 : bitcnt + 1'b1;
                if (word_rd)
                    addr <= addr + 1'b1;
            end else if (state == WRITE && sample_stb) begin
                rx_reg <= {rx_reg[DATA_W-2:0], mosi};
                bitcnt <= word_wr ? '0 : bitcnt + 1'b1;
            end
        end
    end

    // Completed words commit one clk after the last bit, so a cs rise from then on cannot lose them.
    always_ff @(posedge clk) begin
        if (wr_pend)
            mem[addr] <= rx_reg;
        if (mem_re)
            ram_q <= mem[rd_addr];
    end

endmodule
